eh2_dec_trigger_csr: RTL and testbench
======================================

Name: eh2_dec_trigger_csr

Overview:
- Producer side of the trigger packet interface. Holds the per-thread debug trigger CSRs: mtsel, and mtdata1/mtdata2 for triggers 0-3.
- Drives the registered trigger_pkt_any packets consumed by the decode, load/store and other trigger-match logic.
- Accepts CSR writes and reads from the TLU, and records hit status returned from the pipeline.
- Enforces the dmode lock and chain legality rules.

Parameters:
- pt, eh2_param_t (codebase default), design parameter bundle. Uses pt.NUM_THREADS (1 or 2).
- TRIG_CNT, 4, triggers per thread. Fixed; even/odd pairs are used for chaining.

Ports:
- clk  input  1  core clock
- rst_l  input  1  reset. Synchronous, active-low.
- dec_csr_wen  input  1  CSR write strobe, qualified (retiring CSR write)
- dec_csr_wr_tid  input  1  thread of the write
- dec_csr_wraddr  input  12  write address
- dec_csr_wrdata  input  32  write data
- dec_csr_rd_tid  input  1  thread of the read
- dec_csr_rdaddr  input  12  read address
- trig_csr_rddata  output  32  read data, combinational from stored state
- trig_csr_rdhit  output  1  rdaddr is 0x7A0, 0x7A1 or 0x7A2
- dbg_mode  input  NUM_THREADS  thread is in debug mode
- trigger_hit  input  NUM_THREADS x 4  trigger fired (pulse), per thread
- trigger_pkt_any  output  NUM_THREADS x 4 x eh2_trigger_pkt_t  registered packets: select, match, store, load, execute, m, tdata2[31:0]
- trigger_chain  output  NUM_THREADS x 4  stored chain bits; only bits 0 and 2 can be 1
- trigger_action  output  NUM_THREADS x 4  action: 1 = enter debug, 0 = breakpoint exception

Behaviour:
- State per thread t:
  - mtsel[1:0].
  - Per trigger i, mtdata1 stored fields: dmode, hit, select, action, chain, match, m, execute, store, load.
  - tdata2[31:0].
- Reset (rst_l=0 at clk edge): all state 0. trigger_pkt_any, trigger_chain and trigger_action are all 0. trig_csr_rddata follows the stored state, so an mtdata1 read returns 0x23E00000 after reset.
- Writes are applied on the clk edge where dec_csr_wen=1. The new value is visible on trigger_pkt_any and on reads the next cycle (1-cycle latency). Writes to any other address are ignored.
- 0x7A0 (mtsel): mtsel <= wrdata[1:0]. Upper bits are ignored.
- Lock: trigger i is locked when dmode=1 and dbg_mode[t]=0.
  - A write to mtdata1 or mtdata2 of a locked trigger is dropped entirely.
- 0x7A1 (mtdata1), writing t, i=mtsel[t], when not locked:
  - dmode <= wrdata[27] & dbg_mode[t].
  - select <= wrdata[19]; action <= wrdata[12]; match <= wrdata[7]; m <= wrdata[6]; execute <= wrdata[2]; store <= wrdata[1]; load <= wrdata[0].
  - hit <= wrdata[20].
  - chain <= wrdata[11] only if i is 0 or 2; odd triggers force chain to 0.
  - Pair rule: chain for i=0 or i=2 is forced to 0 when trigger i+1 is locked.
- 0x7A2 (mtdata2), when not locked: tdata2 <= wrdata.
- mtdata1 readback layout, MSB to LSB: {4'h2, dmode, 6'h1F, hit, select, 1'b0, 2'b0, 3'b0, action, chain, 3'b0, match, m, 1'b0, 2'b0, execute, store, load}.
- mtdata2 readback: tdata2. mtsel readback: {30'b0, mtsel}. Any other address reads 0 with rdhit=0.
- Hit update: for every t,i with trigger_hit[t][i]=1, hit <= 1 at the clk edge.
- Simultaneous hit and mtdata1 write to the same trigger: the write wins (hit <= wrdata[20]). Hits on other triggers are still applied.
- Hit is set regardless of lock state. Only a CSR write clears hit.
- Thread isolation: a write with wr_tid=t never changes thread !t. Same-cycle hits on both threads are both applied.
- NUM_THREADS=1: tid inputs are ignored and treated as 0.
- Output packets are driven from flops with no combinational path from the write inputs. tdata2 is zero-extended into the packet.

Decomposition:
- eh2_pkg: eh2_trigger_pkt_t (existing). Add eh2_mtdata1_t (the 10 stored fields) and localparams MTSEL=12'h7A0, MTDATA1=12'h7A1, MTDATA2=12'h7A2.
- Sub-module eh2_dec_trigger_csr_thr: one instance per thread. Holds mtsel, 4x mtdata1 and 4x tdata2, the lock/chain logic and its slice of the read mux. The top level does tid decode and final read selection.

Test Plan:
- Reset: hold rst_l=0 for 2 clks -> every trigger_pkt_any field is 0; mtdata1 read returns 0x23E00000; mtsel reads 0.
- Program: write mtsel=1, then mtdata2=0x80001000, then mtdata1=0x00000044 with dbg_mode=0 -> next cycle trigger_pkt_any[0][1] has execute=1, m=1, select=0, match=0, tdata2=0x80001000; mtdata1 reads 0x23E00044.
- Lock: with dbg_mode=1, write mtdata1=0x08001045 to trigger 2. Drop dbg_mode, then write mtdata1=0 -> value is retained (dmode=1, action=1). Same write with dbg_mode=0 from the start -> dmode=0.
- Chain: write 0x00000800 to trigger 1 -> chain reads 0. Write the same to trigger 0 with trigger 1 unlocked -> trigger_chain[0][0]=1. Repeat with trigger 1 locked -> chain=0.
- Hit race: pulse trigger_hit[0][3] while writing mtdata1=0x00000004 to trigger 3 -> hit=0. Pulse trigger_hit[0][3] alone -> bit 20 reads 1.
- Threads (NUM_THREADS=2): write tdata2=0xFFFFFFFF with wr_tid=1 -> thread 0 tdata2 stays 0. Hit pulses on both threads in the same cycle -> both hit bits set.

Source files
------------

// File: rtl/eh2_pkg.sv
// Shared types and constants for the debug trigger CSR block.
package eh2_pkg;

  // Core configuration bundle; only the thread count matters here.
  typedef struct packed {
    int NUM_THREADS;
  } eh2_param_t;

  localparam eh2_param_t EH2_PARAM_DEFAULT = '{NUM_THREADS: 2};

  localparam int TRIG_CNT = 4;

  localparam logic [11:0] MTSEL   = 12'h7A0;
  localparam logic [11:0] MTDATA1 = 12'h7A1;
  localparam logic [11:0] MTDATA2 = 12'h7A2;

  // Packet handed to the trigger-match logic in decode and load/store.
  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } eh2_trigger_pkt_t;

  // Writable/stored fields of one mtdata1 register.
  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } eh2_mtdata1_t;

  // Architectural mtdata1 image: type=2, maskmax=0x1F, hardwired zeros elsewhere.
  function automatic logic [31:0] mtdata1_to_csr(input eh2_mtdata1_t f);
    return {4'h2, f.dmode, 6'h1F, f.hit, f.select, 1'b0, 2'b0, 3'b0,
            f.action, f.chain, 3'b0, f.match, f.m, 1'b0, 2'b0,
            f.execute, f.store, f.load};
  endfunction

endpackage

// File: rtl/eh2_dec_trigger_csr_thr.sv
// Trigger CSR state for one hardware thread: mtsel, four mtdata1/mtdata2
// pairs, dmode lock and chain legality, plus this thread's read mux slice.
module eh2_dec_trigger_csr_thr
  import eh2_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            wen_i,       // already qualified by thread id
  input  logic [11:0]                     wraddr_i,
  input  logic [31:0]                     wrdata_i,
  input  logic                            dbg_mode_i,
  input  logic [TRIG_CNT-1:0]             hit_i,
  input  logic [11:0]                     rdaddr_i,
  output logic [31:0]                     rddata_o,
  output eh2_trigger_pkt_t [TRIG_CNT-1:0] pkt_o,
  output logic [TRIG_CNT-1:0]             chain_o,
  output logic [TRIG_CNT-1:0]             action_o
);

  logic [1:0]                     mtsel_q, mtsel_d;
  eh2_mtdata1_t [TRIG_CNT-1:0]    mtdata1_q, mtdata1_d;
  logic [TRIG_CNT-1:0][31:0]      tdata2_q, tdata2_d;

  logic [TRIG_CNT-1:0] locked;
  logic                sel_locked;
  logic                pair_locked;
  logic                wr_mtsel;
  logic                wr_mtdata1;
  logic                wr_mtdata2;
  eh2_mtdata1_t        wr_fields;

  // A dmode trigger is owned by the debugger and frozen outside debug mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    locked = '0;
    for (int i = 0; i < TRIG_CNT; i++) begin
      locked[i] = mtdata1_q[i].dmode & ~dbg_mode_i;
    end
  end

  assign sel_locked  = locked[mtsel_q];
  // Odd partner of the selected trigger; only meaningful when mtsel is even.
  assign pair_locked = locked[{mtsel_q[1], 1'b1}];

  assign wr_mtsel   = wen_i & (wraddr_i == MTSEL);
  assign wr_mtdata1 = wen_i & (wraddr_i == MTDATA1) & ~sel_locked;
  assign wr_mtdata2 = wen_i & (wraddr_i == MTDATA2) & ~sel_locked;

  // Legalise incoming mtdata1 fields: dmode only settable from debug mode,
  // chain only on even triggers whose odd partner is not locked.
  always_comb begin
    wr_fields         = '0;
    wr_fields.dmode   = wrdata_i[27] & dbg_mode_i;
    wr_fields.hit     = wrdata_i[20];
    wr_fields.select  = wrdata_i[19];
    wr_fields.action  = wrdata_i[12];
    wr_fields.chain   = wrdata_i[11] & ~mtsel_q[0] & ~pair_locked;
    wr_fields.match   = wrdata_i[7];
    wr_fields.m       = wrdata_i[6];
    wr_fields.execute = wrdata_i[2];
    wr_fields.store   = wrdata_i[1];
    wr_fields.load    = wrdata_i[0];
  end

  // Next state: hits set sticky status, a same-trigger mtdata1 write overrides it.
  always_comb begin
    mtsel_d   = mtsel_q;
    mtdata1_d = mtdata1_q;
    tdata2_d  = tdata2_q;
    if (wr_mtsel) begin
      mtsel_d = wrdata_i[1:0];
    end
    for (int i = 0; i < TRIG_CNT; i++) begin
      if (hit_i[i]) begin
        mtdata1_d[i].hit = 1'b1;
      end
    end
    if (wr_mtdata1) begin
      mtdata1_d[mtsel_q] = wr_fields;
    end
    if (wr_mtdata2) begin
      tdata2_d[mtsel_q] = wrdata_i;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      // NOTE: the whole trigger array is reset because its zero state is
      // architecturally visible on reads and on the match packets.
      mtsel_q   <= '0;
      mtdata1_q <= '0;
      tdata2_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mtsel_q   <= mtsel_d;
      mtdata1_q <= mtdata1_d;
      tdata2_q  <= tdata2_d;
    end
  end

  // Match packets come straight from the state flops.
  always_comb begin
    pkt_o    = '0;
    chain_o  = '0;
    action_o = '0;
    for (int i = 0; i < TRIG_CNT; i++) begin
      pkt_o[i] = '{select:  mtdata1_q[i].select,
                   match:   mtdata1_q[i].match,
                   store:   mtdata1_q[i].store,
                   load:    mtdata1_q[i].load,
                   execute: mtdata1_q[i].execute,
                   m:       mtdata1_q[i].m,
                   tdata2:  tdata2_q[i]};
      chain_o[i]  = mtdata1_q[i].chain;
      action_o[i] = mtdata1_q[i].action;
    end
  end

  // Read slice for this thread, indexed by its own mtsel.
  always_comb begin
    rddata_o = '0;
    case (rdaddr_i)
      MTSEL:   rddata_o = {30'b0, mtsel_q};
      MTDATA1: rddata_o = mtdata1_to_csr(mtdata1_q[mtsel_q]);
      MTDATA2: rddata_o = tdata2_q[mtsel_q];
      default: rddata_o = '0;
    endcase
  end

endmodule

// File: rtl/eh2_dec_trigger_csr.sv
// Debug trigger CSR producer: per-thread trigger state, thread-id decode of
// writes and hits, and final read data selection.
module eh2_dec_trigger_csr
  import eh2_pkg::*;
#(
  parameter eh2_param_t pt = EH2_PARAM_DEFAULT
) (
  input  logic                                                clk,
  input  logic                                                rst_l,
  input  logic                                                dec_csr_wen,
  input  logic                                                dec_csr_wr_tid,
  input  logic [11:0]                                         dec_csr_wraddr,
  input  logic [31:0]                                         dec_csr_wrdata,
  input  logic                                                dec_csr_rd_tid,
  input  logic [11:0]                                         dec_csr_rdaddr,
  output logic [31:0]                                         trig_csr_rddata,
  output logic                                                trig_csr_rdhit,
  input  logic [pt.NUM_THREADS-1:0]                           dbg_mode,
  input  logic [pt.NUM_THREADS-1:0][TRIG_CNT-1:0]             trigger_hit,
  output eh2_trigger_pkt_t [pt.NUM_THREADS-1:0][TRIG_CNT-1:0] trigger_pkt_any,
  output logic [pt.NUM_THREADS-1:0][TRIG_CNT-1:0]             trigger_chain,
  output logic [pt.NUM_THREADS-1:0][TRIG_CNT-1:0]             trigger_action
);

  localparam int NT = pt.NUM_THREADS;

  // Single-thread builds force both thread ids to 0.
  logic wr_tid_eff;
  logic rd_tid_eff;
  assign wr_tid_eff = dec_csr_wr_tid & (NT > 1);
  assign rd_tid_eff = dec_csr_rd_tid & (NT > 1);

  logic [NT-1:0]       thr_wen;
  logic [NT-1:0][31:0] thr_rddata;

  for (genvar t = 0; t < NT; t++) begin : g_thr
    assign thr_wen[t] = dec_csr_wen & (wr_tid_eff == 1'(t));

    eh2_dec_trigger_csr_thr u_thr (
      .clk        (clk),
      .rst_l      (rst_l),
      .wen_i      (thr_wen[t]),
      .wraddr_i   (dec_csr_wraddr),
      .wrdata_i   (dec_csr_wrdata),
      .dbg_mode_i (dbg_mode[t]),
      .hit_i      (trigger_hit[t]),
      .rdaddr_i   (dec_csr_rdaddr),
      .rddata_o   (thr_rddata[t]),
      .pkt_o      (trigger_pkt_any[t]),
      .chain_o    (trigger_chain[t]),
      .action_o   (trigger_action[t])
    );
  end

  assign trig_csr_rdhit = (dec_csr_rdaddr == MTSEL) |
                          (dec_csr_rdaddr == MTDATA1) |
                          (dec_csr_rdaddr == MTDATA2);

  // Pick the requesting thread's read slice.
  always_comb begin
    trig_csr_rddata = '0;
    for (int t = 0; t < NT; t++) begin
      if (rd_tid_eff == 1'(t)) begin
        trig_csr_rddata = thr_rddata[t];
      end
    end
  end

endmodule

// File: tb/tb_eh2_dec_trigger_csr.sv
// Directed bench for eh2_dec_trigger_csr with two threads.
module tb_eh2_dec_trigger_csr;
  import eh2_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_l;
  logic                        dec_csr_wen;
  logic                        dec_csr_wr_tid;
  logic [11:0]                 dec_csr_wraddr;
  logic [31:0]                 dec_csr_wrdata;
  logic                        dec_csr_rd_tid;
  logic [11:0]                 dec_csr_rdaddr;
  logic [31:0]                 trig_csr_rddata;
  logic                        trig_csr_rdhit;
  logic [1:0]                  dbg_mode;
  logic [1:0][3:0]             trigger_hit;
  eh2_trigger_pkt_t [1:0][3:0] trigger_pkt_any;
  logic [1:0][3:0]             trigger_chain;
  logic [1:0][3:0]             trigger_action;

  int n_tests = 0;
  int n_fail  = 0;

  eh2_dec_trigger_csr #(.pt('{NUM_THREADS: 2})) dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .dec_csr_wen     (dec_csr_wen),
    .dec_csr_wr_tid  (dec_csr_wr_tid),
    .dec_csr_wraddr  (dec_csr_wraddr),
    .dec_csr_wrdata  (dec_csr_wrdata),
    .dec_csr_rd_tid  (dec_csr_rd_tid),
    .dec_csr_rdaddr  (dec_csr_rdaddr),
    .trig_csr_rddata (trig_csr_rddata),
    .trig_csr_rdhit  (trig_csr_rdhit),
    .dbg_mode        (dbg_mode),
    .trigger_hit     (trigger_hit),
    .trigger_pkt_any (trigger_pkt_any),
    .trigger_chain   (trigger_chain),
    .trigger_action  (trigger_action)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One-cycle qualified CSR write; returns 1 time unit after the capturing edge.
  task automatic csr_wr(input logic tid, input logic [11:0] addr, input logic [31:0] data);
    dec_csr_wen    = 1'b1;
    dec_csr_wr_tid = tid;
    dec_csr_wraddr = addr;
    dec_csr_wrdata = data;
    @(posedge clk);
    #1;
    dec_csr_wen = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic tid, input logic [11:0] addr,
                        input logic [31:0] exp);
    dec_csr_rd_tid = tid;
    dec_csr_rdaddr = addr;
    #1;
    check(tag, trig_csr_rddata, exp);
  endtask

  task automatic pulse_hit(input logic [7:0] h);
    trigger_hit = h;
    @(posedge clk);
    #1;
    trigger_hit = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_l          = 1'b0;
    dec_csr_wen    = 1'b0;
    dec_csr_wr_tid = 1'b0;
    dec_csr_wraddr = '0;
    dec_csr_wrdata = '0;
    dec_csr_rd_tid = 1'b0;
    dec_csr_rdaddr = '0;
    dbg_mode       = '0;
    trigger_hit    = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
    check("rst_pkt_any", 32'(|trigger_pkt_any), 32'h0);
    check("rst_chain_action", {16'h0, trigger_chain, trigger_action}, 32'h0);
    csr_rd("rst_mtdata1", 1'b0, 12'h7A1, 32'h23E0_0000);
    check("rdhit_7a1", 32'(trig_csr_rdhit), 32'h1);
    csr_rd("rst_mtsel", 1'b0, 12'h7A0, 32'h0);
    csr_rd("rd_other_addr", 1'b0, 12'h7A3, 32'h0);
    check("rdhit_7a3", 32'(trig_csr_rdhit), 32'h0);

    // Program trigger 1 of thread 0
    csr_wr(1'b0, 12'h7A0, 32'h1);
    csr_wr(1'b0, 12'h7A2, 32'h8000_1000);
    csr_wr(1'b0, 12'h7A1, 32'h0000_0044);
    check("pkt01_execute", 32'(trigger_pkt_any[0][1].execute), 32'h1);
    check("pkt01_m", 32'(trigger_pkt_any[0][1].m), 32'h1);
    check("pkt01_select", 32'(trigger_pkt_any[0][1].select), 32'h0);
    check("pkt01_match", 32'(trigger_pkt_any[0][1].match), 32'h0);
    check("pkt01_ld_st", 32'({trigger_pkt_any[0][1].load, trigger_pkt_any[0][1].store}), 32'h0);
    check("pkt01_tdata2", trigger_pkt_any[0][1].tdata2, 32'h8000_1000);
    csr_rd("prog_mtdata1", 1'b0, 12'h7A1, 32'h23E0_0044);
    csr_rd("prog_mtdata2", 1'b0, 12'h7A2, 32'h8000_1000);
    csr_rd("prog_mtsel", 1'b0, 12'h7A0, 32'h1);

    // mtsel keeps only the low two bits
    csr_wr(1'b0, 12'h7A0, 32'hFFFF_FFF2);
    csr_rd("mtsel_upper_ignored", 1'b0, 12'h7A0, 32'h2);

    // Lock: dmode trigger written from debug mode, then frozen outside it
    dbg_mode = 2'b01;
    csr_wr(1'b0, 12'h7A1, 32'h0800_1045);
    csr_rd("lock_set", 1'b0, 12'h7A1, 32'h2BE0_1045);
    check("lock_action", 32'(trigger_action[0]), 32'h4);
    dbg_mode = 2'b00;
    csr_wr(1'b0, 12'h7A1, 32'h0);
    csr_rd("lock_mtdata1_kept", 1'b0, 12'h7A1, 32'h2BE0_1045);
    csr_wr(1'b0, 12'h7A2, 32'h0000_1234);
    check("lock_mtdata2_kept", trigger_pkt_any[0][2].tdata2, 32'h0);
    csr_wr(1'b1, 12'h7A0, 32'h2);
    csr_wr(1'b1, 12'h7A1, 32'h0800_1045);
    csr_rd("dmode_needs_dbg", 1'b1, 12'h7A1, 32'h23E0_1045);

    // Chain legality
    csr_wr(1'b0, 12'h7A0, 32'h1);
    csr_wr(1'b0, 12'h7A1, 32'h0000_0800);
    csr_rd("chain_odd_forced0", 1'b0, 12'h7A1, 32'h23E0_0000);
    csr_wr(1'b0, 12'h7A0, 32'h0);
    csr_wr(1'b0, 12'h7A1, 32'h0000_0800);
    check("chain_even_ok", 32'(trigger_chain[0]), 32'h1);
    csr_rd("chain_even_rd", 1'b0, 12'h7A1, 32'h23E0_0800);
    dbg_mode = 2'b01;
    csr_wr(1'b0, 12'h7A0, 32'h1);
    csr_wr(1'b0, 12'h7A1, 32'h0800_0000);
    dbg_mode = 2'b00;
    csr_rd("chain_partner_locked", 1'b0, 12'h7A1, 32'h2BE0_0000);
    csr_wr(1'b0, 12'h7A0, 32'h0);
    csr_wr(1'b0, 12'h7A1, 32'h0000_0800);
    check("chain_pair_locked", 32'(trigger_chain[0]), 32'h0);

    // Hit race: write wins on trigger 3, hit on trigger 1 still lands
    csr_wr(1'b0, 12'h7A0, 32'h3);
    trigger_hit = 8'b0000_1010;
    csr_wr(1'b0, 12'h7A1, 32'h0000_0004);
    trigger_hit = '0;
    csr_rd("hit_race_write_wins", 1'b0, 12'h7A1, 32'h23E0_0004);
    pulse_hit(8'b0000_1100);
    csr_rd("hit_sets_bit20", 1'b0, 12'h7A1, 32'h23F0_0004);
    csr_wr(1'b0, 12'h7A0, 32'h2);
    csr_rd("hit_on_locked", 1'b0, 12'h7A1, 32'h2BF0_1045);
    csr_wr(1'b0, 12'h7A0, 32'h1);
    csr_rd("hit_other_trigger", 1'b0, 12'h7A1, 32'h2BF0_0000);

    // Thread isolation
    csr_wr(1'b1, 12'h7A2, 32'hFFFF_FFFF);
    check("thr1_tdata2", trigger_pkt_any[1][2].tdata2, 32'hFFFF_FFFF);
    check("thr0_tdata2_t2", trigger_pkt_any[0][2].tdata2, 32'h0);
    check("thr0_tdata2_t3", trigger_pkt_any[0][3].tdata2, 32'h0);
    csr_rd("thr1_rd_mtdata2", 1'b1, 12'h7A2, 32'hFFFF_FFFF);
    csr_rd("thr0_rd_mtdata2", 1'b0, 12'h7A2, 32'h8000_1000);
    csr_wr(1'b1, 12'h7A0, 32'h0);
    csr_rd("thr0_mtsel_kept", 1'b0, 12'h7A0, 32'h1);
    csr_wr(1'b0, 12'h7A0, 32'h0);
    pulse_hit(8'b0001_0001);
    csr_rd("both_hit_thr0", 1'b0, 12'h7A1, 32'h23F0_0000);
    csr_rd("both_hit_thr1", 1'b1, 12'h7A1, 32'h23F0_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
